cdc_level_filter: RTL and testbench

Glitch filter and edge-event stage placed directly downstream of the 2-FF synchronizer. It accepts an already synchronized single-bit level and only passes a change through after the new value has held for a programmable number of consecutive cycles. It produces the clean level, one-cycle rise and fall pulses, and a saturating count of assertion events for status readout. Everything runs in the synchronizer's output clock domain.

---
 rtl/cdc_level_filter_if.sv | 33 +++
 rtl/cdc_level_filter.sv | 112 +++++++++++
 tb/tb_cdc_level_filter.sv | 353 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cdc_level_filter_if.sv
// Signal bundle between the synchronizer-side logic and the level filter.
// The filter takes the slave view; whoever drives in_data takes the master view.
interface cdc_level_filter_if #(
    parameter int unsigned EVT_W = 16
);
    logic             in_data;
    logic             cnt_clr;
    logic             out_level;
    logic             out_rise;
    logic             out_fall;
    logic [EVT_W-1:0] evt_count;
    logic             evt_ovf;

    modport master (
        output in_data,
        output cnt_clr,
        input  out_level,
        input  out_rise,
        input  out_fall,
        input  evt_count,
        input  evt_ovf
    );

    modport slave (
        input  in_data,
        input  cnt_clr,
        output out_level,
        output out_rise,
        output out_fall,
        output evt_count,
        output evt_ovf
    );
endinterface

// File: rtl/cdc_level_filter.sv
// Glitch filter behind a 2-FF synchronizer: a level change is passed on only
// after it has held for STABLE_CYCLES samples; emits edge pulses and an event count.
module cdc_level_filter #(
    parameter bit          POLARITY      = 1'b0,
    parameter int unsigned STABLE_CYCLES = 4,
    parameter int unsigned EVT_W         = 16
) (
    input logic               clk,
    input logic               rstn,
    cdc_level_filter_if.slave bus
);
    localparam int unsigned QW = $clog2(STABLE_CYCLES + 1);
    localparam logic [QW-1:0] Q_LAST = QW'(STABLE_CYCLES - 1);

    typedef enum logic {
        IDLE = 1'b0,
        QUAL = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [QW-1:0]    q_q, q_d;
    logic             level_q, level_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;
    logic [EVT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             differ;
    logic             accept;
    logic             event_hit;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            q_q     <= '0;
            level_q <= POLARITY;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    // q counts differing samples seen so far; the STABLE_CYCLES-th one accepts
    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        accept  = 1'b0;
        differ  = bus.in_data != level_q;
        unique case (state_q)
            IDLE: begin
                if (differ) begin
                    if (STABLE_CYCLES == 1) begin
                        accept = 1'b1;
                    end else begin
                        state_d = QUAL;
                        q_d     = QW'(1);
                    end
                end
            end
            QUAL: begin
                if (!differ) begin
                    state_d = IDLE;
                    q_d     = '0;
                end else if (q_q == Q_LAST) begin
                    accept  = 1'b1;
                    state_d = IDLE;
                    q_d     = '0;
                end else begin
                    q_d = q_q + QW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                q_d     = '0;
            end
        endcase
    end

    always_comb begin
        level_d   = accept ? ~level_q : level_q;
        rise_d    = accept & ~level_q;
        fall_d    = accept & level_q;
        event_hit = accept & (level_d != POLARITY);
        cnt_d     = cnt_q;
        ovf_d     = ovf_q;
        // a clear landing on an event still records that event
        if (bus.cnt_clr) begin
            cnt_d = EVT_W'(event_hit);
            ovf_d = 1'b0;
        end else if (event_hit) begin
            if (&cnt_q) begin
                ovf_d = 1'b1;
            end else begin
                cnt_d = cnt_q + EVT_W'(1);
            end
        end
    end

    assign bus.out_level = level_q;
    assign bus.out_rise  = rise_q;
    assign bus.out_fall  = fall_q;
    assign bus.evt_count = cnt_q;
    assign bus.evt_ovf   = ovf_q;
endmodule

// File: tb/tb_cdc_level_filter.sv
// Bench for cdc_level_filter: four parameterisations driven side by side and
// checked against a run-length reference model.
module tb_cdc_level_filter;
    localparam int NI = 4;
    localparam int S [NI] = '{4, 1, 3, 4};
    localparam bit P [NI] = '{1'b0, 1'b0, 1'b0, 1'b1};
    localparam int W [NI] = '{16, 16, 2, 8};

    logic clk;
    logic rstn;
    logic din [NI];
    logic clr [NI];

    logic   a_lvl  [NI];
    logic   a_rise [NI];
    logic   a_fall [NI];
    logic   a_ovf  [NI];
    longint a_cnt  [NI];

    bit     m_lvl  [NI];
    bit     m_rise [NI];
    bit     m_fall [NI];
    bit     m_ovf  [NI];
    int     m_run  [NI];
    longint m_cnt  [NI];

    int n_cmp;
    int n_bad;
    int edge_n;

    cdc_level_filter_if #(.EVT_W(16)) if0 ();
    cdc_level_filter_if #(.EVT_W(16)) if1 ();
    cdc_level_filter_if #(.EVT_W(2))  if2 ();
    cdc_level_filter_if #(.EVT_W(8))  if3 ();

    cdc_level_filter #(.POLARITY(1'b0), .STABLE_CYCLES(4), .EVT_W(16))
        u0 (.clk(clk), .rstn(rstn), .bus(if0));
    cdc_level_filter #(.POLARITY(1'b0), .STABLE_CYCLES(1), .EVT_W(16))
        u1 (.clk(clk), .rstn(rstn), .bus(if1));
    cdc_level_filter #(.POLARITY(1'b0), .STABLE_CYCLES(3), .EVT_W(2))
        u2 (.clk(clk), .rstn(rstn), .bus(if2));
    cdc_level_filter #(.POLARITY(1'b1), .STABLE_CYCLES(4), .EVT_W(8))
        u3 (.clk(clk), .rstn(rstn), .bus(if3));

    assign if0.in_data = din[0];
    assign if1.in_data = din[1];
    assign if2.in_data = din[2];
    assign if3.in_data = din[3];
    assign if0.cnt_clr = clr[0];
    assign if1.cnt_clr = clr[1];
    assign if2.cnt_clr = clr[2];
    assign if3.cnt_clr = clr[3];

    assign a_lvl[0]  = if0.out_level;
    assign a_lvl[1]  = if1.out_level;
    assign a_lvl[2]  = if2.out_level;
    assign a_lvl[3]  = if3.out_level;
    assign a_rise[0] = if0.out_rise;
    assign a_rise[1] = if1.out_rise;
    assign a_rise[2] = if2.out_rise;
    assign a_rise[3] = if3.out_rise;
    assign a_fall[0] = if0.out_fall;
    assign a_fall[1] = if1.out_fall;
    assign a_fall[2] = if2.out_fall;
    assign a_fall[3] = if3.out_fall;
    assign a_ovf[0]  = if0.evt_ovf;
    assign a_ovf[1]  = if1.evt_ovf;
    assign a_ovf[2]  = if2.evt_ovf;
    assign a_ovf[3]  = if3.evt_ovf;
    assign a_cnt[0]  = longint'(if0.evt_count);
    assign a_cnt[1]  = longint'(if1.evt_count);
    assign a_cnt[2]  = longint'(if2.evt_count);
    assign a_cnt[3]  = longint'(if3.evt_count);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        for (int i = 0; i < NI; i++) begin
            m_lvl[i]  = P[i];
            m_rise[i] = 1'b0;
            m_fall[i] = 1'b0;
            m_ovf[i]  = 1'b0;
            m_run[i]  = 0;
            m_cnt[i]  = 0;
        end
    endtask

    // One clock edge: the model sees the inputs held across the edge,
    // then outputs are sampled 1 time unit later.
    task automatic tick();
        bit     acc;
        bit     ev;
        longint cmax;
        @(posedge clk);
        edge_n++;
        for (int i = 0; i < NI; i++) begin
            if (!rstn) begin
                m_lvl[i]  = P[i];
                m_rise[i] = 1'b0;
                m_fall[i] = 1'b0;
                m_ovf[i]  = 1'b0;
                m_run[i]  = 0;
                m_cnt[i]  = 0;
            end else begin
                acc  = 1'b0;
                cmax = (longint'(1) << W[i]) - 1;
                if (din[i] != m_lvl[i]) begin
                    m_run[i]++;
                    if (m_run[i] >= S[i]) begin
                        acc      = 1'b1;
                        m_run[i] = 0;
                    end
                end else begin
                    m_run[i] = 0;
                end
                if (acc) m_lvl[i] = ~m_lvl[i];
                m_rise[i] = acc && m_lvl[i];
                m_fall[i] = acc && !m_lvl[i];
                ev = acc && (m_lvl[i] != P[i]);
                if (clr[i]) begin
                    m_cnt[i] = ev ? 1 : 0;
                    m_ovf[i] = 1'b0;
                end else if (ev) begin
                    if (m_cnt[i] == cmax) m_ovf[i] = 1'b1;
                    else m_cnt[i]++;
                end
            end
        end
        #1;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        for (int i = 0; i < NI; i++) begin
            din[i] = P[i];
            clr[i] = 1'b0;
        end
        model_reset();
        repeat (3) tick();
        for (int i = 0; i < NI; i++) begin
            n_cmp++;
            if (a_lvl[i] !== P[i] || a_rise[i] !== 1'b0 || a_fall[i] !== 1'b0 ||
                a_cnt[i] !== 0 || a_ovf[i] !== 1'b0) begin
                n_bad++;
                $display("FAIL reset inst%0d: got lvl=%b r=%b f=%b cnt=%0d ovf=%b, want lvl=%b r=0 f=0 cnt=0 ovf=0",
                         i, a_lvl[i], a_rise[i], a_fall[i], a_cnt[i], a_ovf[i], P[i]);
            end
        end
    endtask

    task automatic test_basic_accept();
        bit exp_l;
        bit exp_r;
        rstn   = 1'b1;
        edge_n = 0;
        repeat (9) tick();
        din[0] = 1'b1;
        while (edge_n < 15) begin
            tick();
            exp_l = edge_n >= 13;
            exp_r = edge_n == 13;
            n_cmp++;
            if (a_lvl[0] !== exp_l || a_rise[0] !== exp_r || a_fall[0] !== 1'b0 ||
                a_cnt[0] !== (exp_l ? 1 : 0)) begin
                n_bad++;
                $display("FAIL basic_accept edge%0d: got lvl=%b r=%b f=%b cnt=%0d, want lvl=%b r=%b f=0 cnt=%0d",
                         edge_n, a_lvl[0], a_rise[0], a_fall[0], a_cnt[0], exp_l, exp_r, exp_l ? 1 : 0);
            end
        end
    endtask

    task automatic test_glitch();
        int rises;
        int falls;
        din[0] = 1'b0;
        repeat (5) tick();
        for (int c = 0; c < 7; c++) begin
            din[0] = (c < 3);
            tick();
            n_cmp++;
            if (a_lvl[0] !== 1'b0 || a_rise[0] !== 1'b0 || a_fall[0] !== 1'b0 || a_cnt[0] !== 1) begin
                n_bad++;
                $display("FAIL glitch3 c%0d: got lvl=%b r=%b f=%b cnt=%0d, want lvl=0 r=0 f=0 cnt=1",
                         c, a_lvl[0], a_rise[0], a_fall[0], a_cnt[0]);
            end
        end
        rises = 0;
        falls = 0;
        for (int c = 0; c < 10; c++) begin
            din[0] = (c < 4);
            tick();
            rises += int'(a_rise[0]);
            falls += int'(a_fall[0]);
            n_cmp++;
            if (a_lvl[0] !== m_lvl[0] || a_rise[0] !== m_rise[0] || a_fall[0] !== m_fall[0] ||
                a_cnt[0] !== m_cnt[0]) begin
                n_bad++;
                $display("FAIL glitch4 c%0d: got lvl=%b r=%b f=%b cnt=%0d, want lvl=%b r=%b f=%b cnt=%0d",
                         c, a_lvl[0], a_rise[0], a_fall[0], a_cnt[0], m_lvl[0], m_rise[0], m_fall[0], m_cnt[0]);
            end
        end
        n_cmp++;
        if (rises !== 1 || falls !== 1 || a_lvl[0] !== 1'b0 || a_cnt[0] !== 2) begin
            n_bad++;
            $display("FAIL glitch4_total: got rises=%0d falls=%0d lvl=%b cnt=%0d, want 1 1 0 2",
                     rises, falls, a_lvl[0], a_cnt[0]);
        end
    endtask

    task automatic test_s1_toggle();
        longint c0;
        c0 = a_cnt[1];
        for (int c = 1; c <= 20; c++) begin
            din[1] = ~din[1];
            tick();
            n_cmp++;
            if (a_lvl[1] !== din[1] || a_rise[1] !== din[1] || a_fall[1] !== !din[1] ||
                a_cnt[1] !== c0 + (c + 1) / 2) begin
                n_bad++;
                $display("FAIL s1_toggle c%0d: got lvl=%b r=%b f=%b cnt=%0d, want lvl=%b r=%b f=%b cnt=%0d",
                         c, a_lvl[1], a_rise[1], a_fall[1], a_cnt[1], din[1], din[1], !din[1], c0 + (c + 1) / 2);
            end
        end
    endtask

    task automatic test_saturation();
        for (int ev = 1; ev <= 5; ev++) begin
            din[2] = 1'b1;
            repeat (3) tick();
            din[2] = 1'b0;
            repeat (3) tick();
            n_cmp++;
            if (a_cnt[2] !== (ev < 3 ? ev : 3) || a_ovf[2] !== (ev >= 4)) begin
                n_bad++;
                $display("FAIL saturate ev%0d: got cnt=%0d ovf=%b, want cnt=%0d ovf=%b",
                         ev, a_cnt[2], a_ovf[2], ev < 3 ? ev : 3, ev >= 4);
            end
        end
        din[2] = 1'b1;
        repeat (2) tick();
        clr[2] = 1'b1;
        tick();
        clr[2] = 1'b0;
        n_cmp++;
        if (a_cnt[2] !== 1 || a_ovf[2] !== 1'b0 || a_rise[2] !== 1'b1) begin
            n_bad++;
            $display("FAIL clr_with_event: got cnt=%0d ovf=%b r=%b, want cnt=1 ovf=0 r=1",
                     a_cnt[2], a_ovf[2], a_rise[2]);
        end
        clr[2] = 1'b1;
        tick();
        clr[2] = 1'b0;
        n_cmp++;
        if (a_cnt[2] !== 0 || a_ovf[2] !== 1'b0) begin
            n_bad++;
            $display("FAIL clr_alone: got cnt=%0d ovf=%b, want cnt=0 ovf=0", a_cnt[2], a_ovf[2]);
        end
    endtask

    task automatic test_reset_midqual();
        din[3] = 1'b0;
        repeat (4) tick();
        n_cmp++;
        if (a_lvl[3] !== 1'b0 || a_cnt[3] !== 1) begin
            n_bad++;
            $display("FAIL midq_setup: got lvl=%b cnt=%0d, want lvl=0 cnt=1", a_lvl[3], a_cnt[3]);
        end
        din[3] = 1'b1;
        repeat (2) tick();
        #2;
        rstn = 1'b0;
        #1;
        model_reset();
        n_cmp++;
        if (a_lvl[3] !== 1'b1 || a_rise[3] !== 1'b0 || a_fall[3] !== 1'b0 ||
            a_cnt[3] !== 0 || a_ovf[3] !== 1'b0) begin
            n_bad++;
            $display("FAIL midq_async: got lvl=%b r=%b f=%b cnt=%0d ovf=%b, want lvl=1 r=0 f=0 cnt=0 ovf=0",
                     a_lvl[3], a_rise[3], a_fall[3], a_cnt[3], a_ovf[3]);
        end
        din[3] = 1'b0;
        tick();
        #2;
        rstn = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            tick();
            n_cmp++;
            if (a_lvl[3] !== (c < 4) || a_rise[3] !== 1'b0 || a_fall[3] !== (c == 4) ||
                a_cnt[3] !== (c < 4 ? 0 : 1)) begin
                n_bad++;
                $display("FAIL midq_requal c%0d: got lvl=%b r=%b f=%b cnt=%0d, want lvl=%b r=0 f=%b cnt=%0d",
                         c, a_lvl[3], a_rise[3], a_fall[3], a_cnt[3], c < 4, c == 4, c < 4 ? 0 : 1);
            end
        end
    endtask

    task automatic test_polarity();
        din[3] = 1'b1;
        for (int c = 1; c <= 4; c++) tick();
        n_cmp++;
        if (a_lvl[3] !== 1'b1 || a_rise[3] !== 1'b1 || a_fall[3] !== 1'b0 || a_cnt[3] !== 1) begin
            n_bad++;
            $display("FAIL pol_rise: got lvl=%b r=%b f=%b cnt=%0d, want lvl=1 r=1 f=0 cnt=1",
                     a_lvl[3], a_rise[3], a_fall[3], a_cnt[3]);
        end
        din[3] = 1'b0;
        for (int c = 1; c <= 4; c++) tick();
        n_cmp++;
        if (a_lvl[3] !== 1'b0 || a_rise[3] !== 1'b0 || a_fall[3] !== 1'b1 || a_cnt[3] !== 2) begin
            n_bad++;
            $display("FAIL pol_fall: got lvl=%b r=%b f=%b cnt=%0d, want lvl=0 r=0 f=1 cnt=2",
                     a_lvl[3], a_rise[3], a_fall[3], a_cnt[3]);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < NI; i++) begin
                if ($urandom_range(0, 3) == 0) din[i] = ~din[i];
                clr[i] = ($urandom_range(0, 40) == 0);
            end
            tick();
            for (int i = 0; i < NI; i++) begin
                n_cmp++;
                if (a_lvl[i] !== m_lvl[i] || a_rise[i] !== m_rise[i] || a_fall[i] !== m_fall[i] ||
                    a_cnt[i] !== m_cnt[i] || a_ovf[i] !== m_ovf[i]) begin
                    n_bad++;
                    $display("FAIL random c%0d inst%0d: got lvl=%b r=%b f=%b cnt=%0d ovf=%b, want lvl=%b r=%b f=%b cnt=%0d ovf=%b",
                             c, i, a_lvl[i], a_rise[i], a_fall[i], a_cnt[i], a_ovf[i],
                             m_lvl[i], m_rise[i], m_fall[i], m_cnt[i], m_ovf[i]);
                end
            end
        end
        for (int i = 0; i < NI; i++) clr[i] = 1'b0;
    endtask

    initial begin
        n_cmp  = 0;
        n_bad  = 0;
        edge_n = 0;
        test_reset();
        test_basic_accept();
        test_glitch();
        test_s1_toggle();
        test_saturation();
        test_reset_midqual();
        test_polarity();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
